mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one DATA_W-bit 4:1 data multiplexer among four requesters.
- Grants one requester at a time and drives the mux select.
- Moves beats from the granted requester into a single registered output stage with a valid/ready handshake.
- Sits between four producer ports and one downstream consumer.

---
 rtl/mux_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one DATA_W-bit 4:1 mux among four
// requesters, feeding a single registered valid/ready output stage.
// Optional build macro MUX_ARB_STATS_EN adds per-requester saturating accept
// counters readable through stat_idx/stat_cnt.
module mux_rr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [3:0]        gnt,
    output logic [3:0]        ack,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    input  logic [1:0]        stat_idx,
    output logic [15:0]       stat_cnt
`endif
);

    typedef enum logic {
        ARB,
        OWN
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [3:0]        gnt_nxt;
    logic [1:0]        sel_nxt;
    logic [7:0]        beat_cnt, beat_cnt_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic [DATA_W-1:0] mux_data;
    logic [1:0]        winner;
    logic [1:0]        probe;
    logic              win_found;
    logic              space;
    logic              owner_req;
    logic              owner_ack;

    // Shared data mux steered by the registered select.
    always_comb begin
        mux_data = in_data0;
        case (sel)
            2'd0:    mux_data = in_data0;
            2'd1:    mux_data = in_data1;
            2'd2:    mux_data = in_data2;
            default: mux_data = in_data3;
        endcase
    end

    // Rotating priority search starting at ptr.
    always_comb begin
        winner    = ptr;
        win_found = 1'b0;
        probe     = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            probe = ptr + 2'(i);
            if (!win_found && req[probe]) begin
                winner    = probe;
                win_found = 1'b1;
            end
        end
    end

    // Accept a beat from the owner whenever the output stage has room.
    always_comb begin
        space     = !out_valid || out_ready;
        owner_req = req[sel];
        owner_ack = (state == OWN) && owner_req && space;
        ack       = '0;
        ack[sel]  = owner_ack;
    end

    // Next-state, grant, burst counting and output stage update.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        sel_nxt       = sel;
        beat_cnt_nxt  = beat_cnt;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;

        // Output stage is independent of arbitration so a release never drops a pending beat.
        if (owner_ack) begin
            out_data_nxt  = mux_data;
            out_valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            ARB: begin
                gnt_nxt = '0;
                if (win_found) begin
                    state_nxt    = OWN;
                    gnt_nxt      = 4'b0001 << winner;
                    sel_nxt      = winner;
                    beat_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (owner_ack) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                end
                if (!owner_req || (owner_ack && beat_cnt == LAST_BEAT)) begin
                    state_nxt    = ARB;
                    gnt_nxt      = '0;
                    ptr_nxt      = sel + 2'd1;
                    beat_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ARB;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ptr       <= '0;
            gnt       <= '0;
            sel       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            sel       <= sel_nxt;
            beat_cnt  <= beat_cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] stat_ctr [4];

    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stat_ctr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ack[i] && stat_ctr[i] != '1) begin
                    stat_ctr[i] <= stat_ctr[i] + 16'd1;
                end
            end
        end
    end

    // Counter readback.
    always_comb begin
        stat_cnt = stat_ctr[stat_idx];
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (default MAX_BURST=4, DATA_W=8).
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [1:0]  stat_idx;
    logic [15:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .gnt       (gnt),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .stat_idx  (stat_idx),
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'h0;
        out_ready = 1'b1;
        in_data0  = 8'h10;
        in_data1  = 8'h11;
        in_data2  = 8'h12;
        in_data3  = 8'h13;
`ifdef MUX_ARB_STATS_EN
        stat_idx  = 2'd0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'hF;
        out_ready = 1'b1;
        in_data0  = 8'h10;
        in_data1  = 8'h11;
        in_data2  = 8'h12;
        in_data3  = 8'h13;
`ifdef MUX_ARB_STATS_EN
        stat_idx  = 2'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_first_sel: got %0d expected 0", sel); end
    endtask

    task automatic test_single();
        do_reset();
        req      = 4'b0100;
        in_data2 = 8'hA5;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel: got %0d expected 2", sel); end
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_not_yet_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data: got %h expected a5", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
        req = 4'b0000;
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_after_drop: got %b expected 0000", ack); end
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release_gnt: got %b expected 0000", gnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        do_reset();
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp_gnt  = 4'b0001 << (g % 4);
            exp_data = 8'h10 + 8'(g % 4);
            for (int b = 0; b < 4; b++) begin
                @(posedge clk); #1;
                checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL fair_gnt g%0d b%0d: got %b expected %b", g, b, gnt, exp_gnt); end
                checks++; if (ack !== exp_gnt) begin errors++; $display("FAIL fair_ack g%0d b%0d: got %b expected %b", g, b, ack, exp_gnt); end
                checks++; if (sel !== 2'(g % 4)) begin errors++; $display("FAIL fair_sel g%0d b%0d: got %0d expected %0d", g, b, sel, g % 4); end
            end
            @(posedge clk); #1;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_bubble_gnt g%0d: got %b expected 0000", g, gnt); end
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL fair_bubble_ack g%0d: got %b expected 0000", g, ack); end
            checks++; if (out_data !== exp_data) begin errors++; $display("FAIL fair_out_data g%0d: got %h expected %h", g, out_data, exp_data); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fair_out_valid g%0d: got %b expected 1", g, out_valid); end
        end
        req = 4'h0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req       = 4'b0010;
        in_data1  = 8'h11;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL bp_first_ack: got %b expected 0010", ack); end
        @(posedge clk); #1;
        in_data1 = 8'h22;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            #1;
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL bp_stall_ack c%0d: got %b expected 0000", c, ack); end
            checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_stall_data c%0d: got %h expected 11", c, out_data); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid c%0d: got %b expected 1", c, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL bp_release_ack: got %b expected 0010", ack); end
        @(posedge clk); #1;
        checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL bp_new_data: got %h expected 22", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_kept: got %b expected 1", out_valid); end
        req = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        do_reset();
        req      = 4'b0001;
        in_data0 = 8'h3C;
        @(posedge clk); #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_ack1: got %b expected 0001", ack); end
        @(posedge clk); #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_ack2: got %b expected 0001", ack); end
        @(posedge clk); #1;
        req = 4'b0000;
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL drop_no_ack: got %b expected 0000", ack); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL drop_out_data: got %h expected 3c", out_data); end
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release_gnt: got %b expected 0000", gnt); end
        req = 4'b0001;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_regrant0: got %b expected 0001", gnt); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 4'b0000;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release2_gnt: got %b expected 0000", gnt); end
        req = 4'b1001;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_ptr_skip: got %b expected 1000", gnt); end
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL drop_ptr_sel: got %0d expected 3", sel); end
        req = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req       = 4'b0100;
        in_data2  = 8'h5A;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
`ifdef MUX_ARB_STATS_EN
        stat_idx = 2'd2;
        #1;
        checks++; if (stat_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_stat: got %0d expected 1", stat_cnt); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt: got %b expected 0000", gnt); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL mid_sel: got %0d expected 0", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data: got %h expected 00", out_data); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_ack: got %b expected 0000", ack); end
`ifdef MUX_ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            stat_idx = 2'(i);
            #1;
            checks++; if (stat_cnt !== 16'd0) begin errors++; $display("FAIL mid_stat%0d: got %0d expected 0", i, stat_cnt); end
        end
`endif
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
